fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/cpu_pkg.sv | 48 ++++
 rtl/fetch_stage_if.sv | 10 +
 rtl/instr_predecode.sv | 21 ++
 rtl/fetch_stage.sv | 170 +++++++++++++++++
 tb/tb_fetch_stage.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, instruction field positions and
// the fetch-stage state encoding. Used by fetch, decode and the register file.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_IMM   = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

  // Instruction word 1 field positions
  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 11;
  localparam int unsigned RA1_MSB = 10;
  localparam int unsigned RA1_LSB = 8;
  localparam int unsigned RA2_MSB = 7;
  localparam int unsigned RA2_LSB = 5;

  localparam logic [15:0] RESET_VECTOR_ADDR = '0;

  localparam logic [4:0] OPC_HLT = 5'd1;

  // Opcodes followed by an immediate word
  localparam logic [4:0] OPC_2W_A = 5'd12;
  localparam logic [4:0] OPC_2W_B = 5'd13;
  localparam logic [4:0] OPC_2W_C = 5'd20;
  localparam logic [4:0] OPC_2W_D = 5'd21;

  // Opcodes using a single register operand
  localparam logic [4:0] OPC_1OP_A = 5'd3;
  localparam logic [4:0] OPC_1OP_B = 5'd4;
  localparam logic [4:0] OPC_1OP_C = 5'd5;
  localparam logic [4:0] OPC_1OP_D = 5'd14;
  localparam logic [4:0] OPC_1OP_E = 5'd30;
  localparam logic [4:0] OPC_1OP_F = 5'd31;

  function automatic logic is_two_word_op(input logic [4:0] op);
    return (op == OPC_2W_A) || (op == OPC_2W_B) ||
           (op == OPC_2W_C) || (op == OPC_2W_D);
  endfunction

  function automatic logic is_one_operand_op(input logic [4:0] op);
    return (op == OPC_1OP_A) || (op == OPC_1OP_B) || (op == OPC_1OP_C) ||
           (op == OPC_1OP_D) || (op == OPC_1OP_E) || (op == OPC_1OP_F);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory bus between the fetch stage (master) and memory (slave).
//   imem_addr : word address, driven by fetch (equals PC)
//   imem_data : instruction word at imem_addr, same-cycle read
interface fetch_stage_if;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;

  modport master (output imem_addr, input imem_data);
  modport slave  (input imem_addr, output imem_data);
endinterface

// File: rtl/instr_predecode.sv
// Combinational opcode classifier.
//   opcode         : instruction bits [15:11]
//   is_two_word    : instruction carries a second (immediate) word
//   is_halt        : HLT instruction
//   is_one_operand : instruction reads a single register operand
module instr_predecode
  import cpu_pkg::*;
(
  input  logic [4:0] opcode,
  output logic       is_two_word,
  output logic       is_halt,
  output logic       is_one_operand
);

  always_comb begin
    is_two_word    = is_two_word_op(opcode);
    is_halt        = (opcode == OPC_HLT);
    is_one_operand = is_one_operand_op(opcode);
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, assembles one- and two-word
// instructions into the IF/ID pipeline register, and handles redirect,
// stall, halt and the reset-vector boot.
//   clk, reset_n       : clock, async active-low reset
//   imem               : instruction memory bus (imem_addr = PC)
//   stall              : hold request from decode
//   branch_taken/target: redirect request, squashes IF/ID
//   if_id_*            : IF/ID register contents
//   opcode, read_addr* : fields of if_id_instr
//   one_operand        : registered single-operand flag for if_id_instr
module fetch_stage
  import cpu_pkg::*;
(
  input  logic           clk,
  input  logic           reset_n,
  fetch_stage_if.master  imem,
  input  logic           stall,
  input  logic           branch_taken,
  input  logic [15:0]    branch_target,
  output logic           if_id_valid,
  output logic [15:0]    if_id_instr,
  output logic [15:0]    if_id_imm,
  output logic [15:0]    if_id_pc,
  output logic [4:0]     opcode,
  output logic [2:0]     read_addr1,
  output logic [2:0]     read_addr2,
  output logic           one_operand
);

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  hold_q, hold_d;
  logic         valid_q, valid_d;
  logic [15:0]  instr_q, instr_d;
  logic [15:0]  imm_q, imm_d;
  logic [15:0]  ifpc_q, ifpc_d;
  logic         one_op_q, one_op_d;

  logic [15:0]  pc_inc;
  logic         fw_two_word, fw_halt, fw_one_op;
  logic         hold_two_word, hold_halt, hold_one_op;

  // Classify the word on the memory bus (FETCH) and the held word 1 (IMM)
  instr_predecode u_pd_fetch (
    .opcode         (imem.imem_data[OPC_MSB:OPC_LSB]),
    .is_two_word    (fw_two_word),
    .is_halt        (fw_halt),
    .is_one_operand (fw_one_op)
  );

  instr_predecode u_pd_hold (
    .opcode         (hold_q[OPC_MSB:OPC_LSB]),
    .is_two_word    (hold_two_word),
    .is_halt        (hold_halt),
    .is_one_operand (hold_one_op)
  );

  assign pc_inc = pc_q + 16'd1;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    hold_d   = hold_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    imm_d    = imm_q;
    ifpc_d   = ifpc_q;
    one_op_d = one_op_q;

    if (state_q == ST_BOOT) begin
      // Memory is addressed at the reset vector; its word is the start PC.
      // Redirect and stall are both ignored here.
      pc_d     = imem.imem_data;
      valid_d  = 1'b0;
      instr_d  = '0;
      imm_d    = '0;
      one_op_d = 1'b0;
      state_d  = ST_FETCH;
    end else if (branch_taken) begin
      pc_d     = branch_target;
      hold_d   = '0;
      valid_d  = 1'b0;
      instr_d  = '0;
      imm_d    = '0;
      one_op_d = 1'b0;
      state_d  = ST_FETCH;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (!stall) begin
            if (fw_halt) begin
              valid_d  = 1'b1;
              instr_d  = imem.imem_data;
              imm_d    = '0;
              ifpc_d   = pc_inc;
              one_op_d = fw_one_op;
              state_d  = ST_HALT;
            end else if (fw_two_word) begin
              hold_d   = imem.imem_data;
              pc_d     = pc_inc;
              valid_d  = 1'b0;
              instr_d  = '0;
              imm_d    = '0;
              one_op_d = 1'b0;
              state_d  = ST_IMM;
            end else begin
              valid_d  = 1'b1;
              instr_d  = imem.imem_data;
              imm_d    = '0;
              ifpc_d   = pc_inc;
              one_op_d = fw_one_op;
              pc_d     = pc_inc;
            end
          end
        end
        ST_IMM: begin
          if (!stall) begin
            valid_d  = 1'b1;
            instr_d  = hold_q;
            imm_d    = imem.imem_data;
            ifpc_d   = pc_inc;
            one_op_d = hold_one_op;
            pc_d     = pc_inc;
            state_d  = ST_FETCH;
          end
        end
        ST_HALT: begin
          valid_d  = 1'b0;
          instr_d  = '0;
          imm_d    = '0;
          one_op_d = 1'b0;
        end
        default: state_d = ST_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_BOOT;
      pc_q     <= RESET_VECTOR_ADDR;
      hold_q   <= '0;
      valid_q  <= 1'b0;
      instr_q  <= '0;
      imm_q    <= '0;
      ifpc_q   <= '0;
      one_op_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      hold_q   <= hold_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      imm_q    <= imm_d;
      ifpc_q   <= ifpc_d;
      one_op_q <= one_op_d;
    end
  end

  assign imem.imem_addr = pc_q;
  assign if_id_valid    = valid_q;
  assign if_id_instr    = instr_q;
  assign if_id_imm      = imm_q;
  assign if_id_pc       = ifpc_q;
  assign one_operand    = one_op_q;
  assign opcode         = instr_q[OPC_MSB:OPC_LSB];
  assign read_addr1     = instr_q[RA1_MSB:RA1_LSB];
  assign read_addr2     = instr_q[RA2_MSB:RA2_LSB];

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        if_id_valid;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_imm;
  logic [15:0] if_id_pc;
  logic [4:0]  opcode;
  logic [2:0]  read_addr1;
  logic [2:0]  read_addr2;
  logic        one_operand;

  logic [15:0] mem [0:65535];

  int checks;
  int failures;

  fetch_stage_if imem_bus ();

  assign imem_bus.imem_data = mem[imem_bus.imem_addr];

  fetch_stage dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .imem          (imem_bus.master),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .if_id_valid   (if_id_valid),
    .if_id_instr   (if_id_instr),
    .if_id_imm     (if_id_imm),
    .if_id_pc      (if_id_pc),
    .opcode        (opcode),
    .read_addr1    (read_addr1),
    .read_addr2    (read_addr2),
    .one_operand   (one_operand)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        br;
    logic [15:0] target;
    logic        valid;
    logic [15:0] instr;
    logic [15:0] imm;
    logic [15:0] ifpc;
    logic        one_op;
    logic [15:0] addr;
  } vec_t;

  vec_t vecs [$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic v, input logic [15:0] ins,
                         input logic [15:0] im, input logic [15:0] pc,
                         input logic one, input logic [15:0] addr);
    logic [15:0] e_ins;
    e_ins = ins;
    chk({tag, ".valid"},  {15'd0, if_id_valid}, {15'd0, v});
    chk({tag, ".instr"},  if_id_instr, ins);
    chk({tag, ".imm"},    if_id_imm, im);
    chk({tag, ".pc"},     if_id_pc, pc);
    chk({tag, ".oneop"},  {15'd0, one_operand}, {15'd0, one});
    chk({tag, ".addr"},   imem_bus.imem_addr, addr);
    chk({tag, ".opcode"}, {11'd0, opcode}, {11'd0, e_ins[15:11]});
    chk({tag, ".ra1"},    {13'd0, read_addr1}, {13'd0, e_ins[10:8]});
    chk({tag, ".ra2"},    {13'd0, read_addr2}, {13'd0, e_ins[7:5]});
  endtask

  task automatic add(input logic s, input logic b, input logic [15:0] t,
                     input logic v, input logic [15:0] ins, input logic [15:0] im,
                     input logic [15:0] pc, input logic one, input logic [15:0] addr);
    vec_t r;
    r.stall = s; r.br = b; r.target = t; r.valid = v; r.instr = ins;
    r.imm = im; r.ifpc = pc; r.one_op = one; r.addr = addr;
    vecs.push_back(r);
  endtask

  // Apply inputs, take one edge, sample 1 time unit later
  task automatic step(input logic s, input logic b, input logic [15:0] t);
    stall = s; branch_taken = b; branch_target = t;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset_n = 1'b0;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = '0;

    // Background fill: opcode 2 (one-word, no flags), low bits = address
    for (int unsigned a = 0; a < 65536; a++) mem[a] = 16'h1000 | (a[15:0] & 16'h07FF);
    mem[16'h0000] = 16'h0010;  // reset vector
    mem[16'h0010] = 16'h1D60;  // op 3, one-operand, ra1=5 ra2=3
    mem[16'h0020] = 16'h6120;  // op 12, two-word
    mem[16'h0021] = 16'hBEEF;
    mem[16'h0022] = 16'h6923;  // op 13, two-word
    mem[16'h0023] = 16'h1234;
    mem[16'h0024] = 16'hA0E0;  // op 20, two-word
    mem[16'h0025] = 16'h5555;
    mem[16'h0030] = 16'h0800;  // HLT
    mem[16'h0040] = 16'hF8A0;  // op 31, one-operand
    mem[16'hFFFF] = 16'h2B40;  // op 5, one-operand

    //   stall br target   valid instr    imm      ifpc     one addr
    add(0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0010); // BOOT
    add(0, 0, 16'h0000, 1, 16'h1D60, 16'h0000, 16'h0011, 1, 16'h0011);
    add(0, 0, 16'h0000, 1, 16'h1011, 16'h0000, 16'h0012, 0, 16'h0012);
    add(1, 0, 16'h0000, 1, 16'h1011, 16'h0000, 16'h0012, 0, 16'h0012); // stall in FETCH
    add(0, 1, 16'h0020, 0, 16'h0000, 16'h0000, 16'h0012, 0, 16'h0020); // branch
    add(0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0012, 0, 16'h0021); // word 1
    add(0, 0, 16'h0000, 1, 16'h6120, 16'hBEEF, 16'h0022, 0, 16'h0022); // IMM done
    add(0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0022, 0, 16'h0023);
    add(1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0022, 0, 16'h0023); // 3x stall in IMM
    add(1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0022, 0, 16'h0023);
    add(1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0022, 0, 16'h0023);
    add(0, 0, 16'h0000, 1, 16'h6923, 16'h1234, 16'h0024, 0, 16'h0024);
    add(0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0024, 0, 16'h0025);
    add(1, 1, 16'h0100, 0, 16'h0000, 16'h0000, 16'h0024, 0, 16'h0100); // branch+stall in IMM
    add(0, 0, 16'h0000, 1, 16'h1100, 16'h0000, 16'h0101, 0, 16'h0101);
    add(0, 1, 16'h0030, 0, 16'h0000, 16'h0000, 16'h0101, 0, 16'h0030);
    add(0, 0, 16'h0000, 1, 16'h0800, 16'h0000, 16'h0031, 0, 16'h0030); // HLT
    add(1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0031, 0, 16'h0030); // HALT, stall
    add(0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0031, 0, 16'h0030);
    add(0, 1, 16'h0040, 0, 16'h0000, 16'h0000, 16'h0031, 0, 16'h0040); // leave HALT
    add(0, 0, 16'h0000, 1, 16'hF8A0, 16'h0000, 16'h0041, 1, 16'h0041);
    add(0, 1, 16'hFFFF, 0, 16'h0000, 16'h0000, 16'h0041, 0, 16'hFFFF);
    add(0, 0, 16'h0000, 1, 16'h2B40, 16'h0000, 16'h0000, 1, 16'h0000); // wrap
    add(0, 0, 16'h0000, 1, 16'h0010, 16'h0000, 16'h0001, 0, 16'h0001);

    // Reset state
    #12;
    chk_all("reset", 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].stall, vecs[i].br, vecs[i].target);
      chk_all($sformatf("vec%0d", i), vecs[i].valid, vecs[i].instr, vecs[i].imm,
              vecs[i].ifpc, vecs[i].one_op, vecs[i].addr);
    end

    // Reset mid-IMM: asynchronous clear, then BOOT restarts (branch ignored in BOOT)
    step(0, 1, 16'h0020);
    step(0, 0, 16'h0000);   // word 1 of 0x0020 taken, now in IMM
    #2;
    reset_n = 1'b0;
    #1;
    chk_all("rst_imm", 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step(0, 1, 16'h0055);   // BOOT edge with redirect request
    chk_all("boot_br", 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0010);
    step(0, 0, 16'h0000);
    chk_all("after_boot", 1, 16'h1D60, 16'h0000, 16'h0011, 1, 16'h0011);

    // Reset mid-stall: stall stays asserted across reset; BOOT ignores it
    step(1, 0, 16'h0000);
    chk_all("stall_hold", 1, 16'h1D60, 16'h0000, 16'h0011, 1, 16'h0011);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all("rst_stall", 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step(1, 0, 16'h0000);
    chk_all("boot_stall", 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0010);
    step(0, 0, 16'h0000);
    chk_all("resume", 1, 16'h1D60, 16'h0000, 16'h0011, 1, 16'h0011);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
